// File: rtl/hub75_scan_pkg.sv
// Shared types and helpers for the HUB75 scan driver: FSM states, pixel-word
// field layout and the frame RAM address packing.
package hub75_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_e;

    localparam int NUM_CH = 6;
    localparam int CH_R1  = 0;
    localparam int CH_G1  = 1;
    localparam int CH_B1  = 2;
    localparam int CH_R2  = 3;
    localparam int CH_G2  = 4;
    localparam int CH_B2  = 5;

    // LSB of a colour channel inside the {B2,G2,R2,B1,G1,R1} pixel-pair word
    function automatic int field_lsb(input int ch, input int bpc);
        return ch * bpc;
    endfunction

    function automatic logic [31:0] pack_addr(input logic [31:0] row,
                                              input logic [31:0] col,
                                              input int          col_w);
        return (row << col_w) | col;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-code-modulation on-time counter: loads BASE_CYCLES<<plane and flags
// the last cycle of the display window.
module hub75_bcm_timer #(
    parameter int BPC         = 8,
    parameter int BASE_CYCLES = 8,
    parameter int PL_W        = (BPC > 1) ? $clog2(BPC) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            run,
    input  logic [PL_W-1:0] plane,
    output logic            done
);

    localparam int MAX_D = BASE_CYCLES << (BPC - 1);
    localparam int CNT_W = $clog2(MAX_D + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] ld_val;

    assign base   = CNT_W'(BASE_CYCLES);
    assign ld_val = base << plane;

    // cnt counts down to zero; zero is the final display cycle
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= ld_val - CNT_W'(1);
        else if (run && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign done = run && (cnt == '0);

endmodule

// File: rtl/hub75_scan.sv
// Frame RAM read-out and HUB75 panel driver: shifts one bit plane per scan row,
// latches it and lights it for a binary-weighted time, looping over planes/rows.
module hub75_scan
    import hub75_scan_pkg::*;
#(
    parameter int COLS        = 64,
    parameter int ROW_W       = 5,
    parameter int BPC         = 8,
    parameter int BASE_CYCLES = 8,
    parameter int RD_LAT      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    output logic [ROW_W+$clog2(COLS)-1:0] raddr,
    output logic                          re,
    input  logic [6*BPC-1:0]              rdata,
    output logic                          hub_r1,
    output logic                          hub_g1,
    output logic                          hub_b1,
    output logic                          hub_r2,
    output logic                          hub_g2,
    output logic                          hub_b2,
    output logic                          hub_clk,
    output logic                          hub_lat,
    output logic                          hub_oe_n,
    output logic [ROW_W-1:0]              hub_addr,
    output logic                          frame_start,
    output logic                          busy
);

    localparam int COL_W     = $clog2(COLS);
    localparam int ADDR_W    = ROW_W + COL_W;
    localparam int PL_W      = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int SHIFT_LEN = 2 * COLS + RD_LAT + 1;
    localparam int SC_W      = $clog2(SHIFT_LEN);
    localparam int STAGES    = RD_LAT + 1;

    state_e            state, state_nx;
    logic [ROW_W-1:0]  row;
    logic [PL_W-1:0]   plane;
    logic [SC_W-1:0]   sc;
    logic [COL_W-1:0]  col;
    logic              shift_last;
    logic              last_plane;
    logic              last_row;
    logic              tmr_load;
    logic              tmr_done;
    logic [STAGES:0]   vld_pipe;
    logic [NUM_CH-1:0] plane_bits;
    logic [NUM_CH-1:0] colour;

    assign col        = sc[COL_W:1];
    assign shift_last = (sc == SC_W'(SHIFT_LEN - 1));
    assign last_plane = (plane == PL_W'(BPC - 1));
    assign last_row   = &row;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // en only matters at IDLE and at frame completion
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (en) state_nx = SHIFT;
            SHIFT:   if (shift_last) state_nx = BLANK;
            BLANK:   state_nx = LATCH;
            LATCH:   state_nx = DISPLAY;
            DISPLAY: if (tmr_done)
                         state_nx = (last_plane && last_row && !en) ? IDLE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        re          = 1'b0;
        hub_lat     = 1'b0;
        hub_oe_n    = 1'b1;
        busy        = 1'b1;
        frame_start = 1'b0;
        tmr_load    = 1'b0;
        unique case (state)
            IDLE:    busy = 1'b0;
            SHIFT: begin
                re          = (sc < SC_W'(2 * COLS)) && !sc[0];
                frame_start = (sc == '0) && (row == '0) && (plane == '0);
            end
            LATCH: begin
                hub_lat  = 1'b1;
                tmr_load = 1'b1;
            end
            DISPLAY: hub_oe_n = 1'b0;
            default: ;
        endcase
    end

    assign raddr = re ? ADDR_W'(pack_addr(32'(row), 32'(col), COL_W)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sc       <= '0;
            row      <= '0;
            plane    <= '0;
            hub_addr <= '0;
        end else begin
            sc <= (state == SHIFT && !shift_last) ? sc + SC_W'(1) : '0;
            // row select moves on entry to BLANK, after the last shift clock
            if (state == SHIFT && shift_last)
                hub_addr <= row;
            if (state == DISPLAY && tmr_done) begin
                plane <= last_plane ? '0 : plane + PL_W'(1);
                if (last_plane)
                    row <= row + ROW_W'(1);
            end
        end
    end

    // vld_pipe[k] is high k+1 cycles after a read; rdata is live at RD_LAT-1
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:0], re};
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam int LSB = field_lsb(g, BPC);
        logic [BPC-1:0] chan;
        assign chan          = rdata[LSB +: BPC];
        assign plane_bits[g] = chan[plane];
    end

    always_ff @(posedge clk) begin
        if (rst)
            colour <= '0;
        else if (vld_pipe[RD_LAT-1])
            colour <= plane_bits;
    end

    // shift clock rises one cycle after the data it qualifies
    assign hub_clk = vld_pipe[STAGES];

    assign hub_r1 = colour[CH_R1];
    assign hub_g1 = colour[CH_G1];
    assign hub_b1 = colour[CH_B1];
    assign hub_r2 = colour[CH_R2];
    assign hub_g2 = colour[CH_G2];
    assign hub_b2 = colour[CH_B2];

    hub75_bcm_timer #(
        .BPC        (BPC),
        .BASE_CYCLES(BASE_CYCLES),
        .PL_W       (PL_W)
    ) u_bcm_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .run  (state == DISPLAY),
        .plane(plane),
        .done (tmr_done)
    );

endmodule
